modbus_rsp_tx: RTL and testbench

MODBUS_RSP_TX -- requirements
Module: modbus_rsp_tx

---
 rtl/modbus_rsp_tx_if.sv | 25 ++
 rtl/modbus_rsp_tx.sv | 174 +++++++++++++++++
 tb/tb_modbus_rsp_tx.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_rsp_tx_if.sv
// Request and byte-stream signals of the Modbus RTU response transmitter.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; the
// sender holds valid and its payload stable until that edge, ready may toggle freely.
`timescale 1ns/1ps
interface modbus_rsp_tx_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_func;
    logic [15:0] cmd_reg;
    logic [15:0] cmd_data;
    logic [7:0]  cmd_exc;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready;

    modport master (
        output cmd_valid, cmd_func, cmd_reg, cmd_data, cmd_exc, tx_ready,
        input  cmd_ready, tx_valid, tx_byte
    );

    modport slave (
        input  cmd_valid, cmd_func, cmd_reg, cmd_data, cmd_exc, tx_ready,
        output cmd_ready, tx_valid, tx_byte
    );
endinterface

// File: rtl/modbus_rsp_tx.sv
// Modbus RTU response framer: waits the inter-frame gap, then streams the
// response payload followed by its CRC-16/MODBUS (low byte first).
`timescale 1ns/1ps
module modbus_rsp_tx #(
    parameter logic [7:0]  MODBUS_ADDR = 8'h01,
    parameter int unsigned GAP_CYCLES  = 182292
) (
    input  logic              clk,
    input  logic              rst_n,
    modbus_rsp_tx_if.slave    bus,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP    = 3'd1,
        S_SEND   = 3'd2,
        S_CRC_LO = 3'd3,
        S_CRC_HI = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [2:0]       idx_q, idx_d;
    logic [15:0]      crc_q, crc_d;
    logic [7:0]       func_q, func_d;
    logic [15:0]      reg_q, reg_d;
    logic [15:0]      data_q, data_d;
    logic [7:0]       exc_q, exc_d;
    logic             armed_q;

    logic             accept;
    logic             tx_hs;
    logic [2:0]       pay_len;
    logic [7:0]       pay_byte;

    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Any nonzero exception code, or an unsupported function, produces the
    // 3-byte exception frame with bit 7 of the function code set.
    always_comb begin
        pay_len  = 3'd3;
        pay_byte = 8'h00;
        if (exc_q == 8'h00 && func_q == 8'h03) begin
            pay_len = 3'd5;
            case (idx_q)
                3'd0:    pay_byte = MODBUS_ADDR;
                3'd1:    pay_byte = 8'h03;
                3'd2:    pay_byte = 8'h02;
                3'd3:    pay_byte = data_q[15:8];
                default: pay_byte = data_q[7:0];
            endcase
        end else if (exc_q == 8'h00 && func_q == 8'h06) begin
            pay_len = 3'd6;
            case (idx_q)
                3'd0:    pay_byte = MODBUS_ADDR;
                3'd1:    pay_byte = 8'h06;
                3'd2:    pay_byte = reg_q[15:8];
                3'd3:    pay_byte = reg_q[7:0];
                3'd4:    pay_byte = data_q[15:8];
                default: pay_byte = data_q[7:0];
            endcase
        end else begin
            case (idx_q)
                3'd0:    pay_byte = MODBUS_ADDR;
                3'd1:    pay_byte = func_q | 8'h80;
                default: pay_byte = (exc_q != 8'h00) ? exc_q : 8'h01;
            endcase
        end
    end

    assign bus.cmd_ready = armed_q && (state_q == S_IDLE);
    assign bus.tx_valid  = (state_q == S_SEND) || (state_q == S_CRC_LO) || (state_q == S_CRC_HI);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign tx_hs         = bus.tx_valid && bus.tx_ready;
    assign busy_o        = (state_q != S_IDLE);
    assign frame_done_o  = (state_q == S_DONE);
    assign state_o       = state_q;

    always_comb begin
        case (state_q)
            S_SEND:   bus.tx_byte = pay_byte;
            S_CRC_LO: bus.tx_byte = crc_q[7:0];
            S_CRC_HI: bus.tx_byte = crc_q[15:8];
            default:  bus.tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        crc_d   = crc_q;
        func_d  = func_q;
        reg_d   = reg_q;
        data_d  = data_q;
        exc_d   = exc_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    func_d  = bus.cmd_func;
                    reg_d   = bus.cmd_reg;
                    data_d  = bus.cmd_data;
                    exc_d   = bus.cmd_exc;
                    crc_d   = 16'hFFFF;
                    idx_d   = 3'd0;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? S_SEND : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_SEND: begin
                if (tx_hs) begin
                    crc_d = crc_step(crc_q, pay_byte);
                    if (idx_q == pay_len - 3'd1) begin
                        idx_d   = 3'd0;
                        state_d = S_CRC_LO;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_CRC_LO: if (tx_hs) state_d = S_CRC_HI;
            S_CRC_HI: if (tx_hs) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            idx_q   <= 3'd0;
            crc_q   <= 16'hFFFF;
            func_q  <= 8'h00;
            reg_q   <= 16'h0000;
            data_q  <= 16'h0000;
            exc_q   <= 8'h00;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            crc_q   <= crc_d;
            func_q  <= func_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
            armed_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_modbus_rsp_tx.sv
// Directed bench for modbus_rsp_tx: one instance with a 4-cycle gap, one with no gap.
`timescale 1ns/1ps
module tb_modbus_rsp_tx;

    logic clk;
    logic rst_n;
    logic busy4, fd4, busy0, fd0;
    logic [2:0] st4, st0;

    modbus_rsp_tx_if b4 ();
    modbus_rsp_tx_if b0 ();

    modbus_rsp_tx #(.MODBUS_ADDR(8'h01), .GAP_CYCLES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(b4.slave),
        .busy_o(busy4), .frame_done_o(fd4), .state_o(st4)
    );

    modbus_rsp_tx #(.MODBUS_ADDR(8'h01), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave),
        .busy_o(busy0), .frame_done_o(fd0), .state_o(st0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Bitwise CRC-16/MODBUS over the current expected payload.
    function automatic logic [15:0] crc_of_exp();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (exp_q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ exp_q[i][b];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic push_crc();
        logic [15:0] c;
        c = crc_of_exp();
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
    endtask

    // driver tasks
    task automatic issue(input logic [7:0] func, input logic [15:0] rg, input logic [15:0] data,
                         input logic [7:0] exc);
        @(negedge clk);
        b4.cmd_func  = func;
        b4.cmd_reg   = rg;
        b4.cmd_data  = data;
        b4.cmd_exc   = exc;
        b4.cmd_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (b4.cmd_valid && b4.cmd_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("accept", ok, 1'b1);
    endtask

    task automatic scramble_cmd();
        b4.cmd_valid = 1'b0;
        b4.cmd_func  = 8'($urandom_range(0, 255));
        b4.cmd_reg   = 16'($urandom_range(0, 65535));
        b4.cmd_data  = 16'($urandom_range(0, 65535));
        b4.cmd_exc   = 8'($urandom_range(0, 255));
    endtask

    // Starts right after the accept edge; collects one frame and scores it against exp_q.
    task automatic recv_frame(input bit rnd, input string tag);
        logic [7:0] got_q[$];
        int   first, cycles, stall_err, rdy_err;
        bit   done_seen, prev_stall;
        logic [7:0] prev_byte;
        first = -1; cycles = 0; stall_err = 0; rdy_err = 0;
        done_seen = 1'b0; prev_stall = 1'b0; prev_byte = 8'h00;
        while (!done_seen && cycles < 400) begin
            @(negedge clk);
            cycles++;
            b4.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b4.tx_valid && first < 0) first = cycles;
            if (prev_stall && b4.tx_byte !== prev_byte) stall_err++;
            if (busy4 && b4.cmd_ready) rdy_err++;
            if (b4.tx_valid && b4.tx_ready) got_q.push_back(b4.tx_byte);
            prev_stall = b4.tx_valid && !b4.tx_ready;
            prev_byte  = b4.tx_byte;
            if (fd4) done_seen = 1'b1;
        end
        b4.tx_ready = 1'b1;
        check({tag, "_done"}, done_seen, 1'b1);
        check({tag, "_latency"}, first, 5);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        check({tag, "_stable"}, stall_err, 0);
        check({tag, "_rdy_busy"}, rdy_err, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, fd4, 1'b0);
    endtask

    initial begin
        logic [7:0] got0_q[$];
        int cyc;

        rst_n = 1'b0;
        b4.cmd_valid = 1'b0; b4.cmd_func = 8'h00; b4.cmd_reg = 16'h0; b4.cmd_data = 16'h0;
        b4.cmd_exc = 8'h00; b4.tx_ready = 1'b1;
        b0.cmd_valid = 1'b0; b0.cmd_func = 8'h00; b0.cmd_reg = 16'h0; b0.cmd_data = 16'h0;
        b0.cmd_exc = 8'h00; b0.tx_ready = 1'b1;

        #2;
        check("rst_tx_valid", b4.tx_valid, 1'b0);
        check("rst_tx_byte", b4.tx_byte, 8'h00);
        check("rst_busy", busy4, 1'b0);
        check("rst_cmd_ready", b4.cmd_ready, 1'b0);
        check("rst_frame_done", fd4, 1'b0);
        check("rst_state", st4, 3'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rdy_after_rst", b4.cmd_ready, 1'b1);
        check("rdy_after_rst0", b0.cmd_ready, 1'b1);

        // write single register echo
        exp_q = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        issue(8'h06, 16'h0001, 16'h0003, 8'h00);
        wait_accept();
        scramble_cmd();
        recv_frame(1'b0, "wr");

        // explicit exception code
        exp_q = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
        issue(8'h03, 16'h0000, 16'h0000, 8'h02);
        wait_accept();
        scramble_cmd();
        recv_frame(1'b0, "exc");

        // unsupported function -> illegal function exception
        exp_q = '{8'h01, 8'h90, 8'h01};
        push_crc();
        issue(8'h10, 16'h1234, 16'h5678, 8'h00);
        wait_accept();
        scramble_cmd();
        recv_frame(1'b0, "badfn");

        // read with a randomly stalling transmitter
        exp_q = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h0A};
        push_crc();
        issue(8'h03, 16'h0000, 16'h000A, 8'h00);
        wait_accept();
        scramble_cmd();
        recv_frame(1'b1, "rd_stall");

        // second request held during a frame
        exp_q = '{8'h01, 8'h03, 8'h02, 8'h12, 8'h34};
        push_crc();
        issue(8'h03, 16'h0000, 16'h1234, 8'h00);
        wait_accept();
        b4.cmd_func = 8'h06; b4.cmd_reg = 16'h00AB; b4.cmd_data = 16'h5555; b4.cmd_exc = 8'h00;
        recv_frame(1'b0, "hold1");
        check("hold_accept_now", b4.cmd_ready, 1'b1);
        exp_q = '{8'h01, 8'h06, 8'h00, 8'hAB, 8'h55, 8'h55};
        push_crc();
        wait_accept();
        scramble_cmd();
        recv_frame(1'b0, "hold2");

        // reset while byte 3 is on the bus
        issue(8'h06, 16'h0001, 16'h0003, 8'h00);
        wait_accept();
        scramble_cmd();
        cyc = 0;
        while (!b4.tx_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_valid_seen", b4.tx_valid, 1'b1);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("mid_byte3", b4.tx_byte, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", b4.tx_valid, 1'b0);
        check("mid_rst_busy", busy4, 1'b0);
        check("mid_rst_tx_byte", b4.tx_byte, 8'h00);
        check("mid_rst_ready", b4.cmd_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_ready", b4.cmd_ready, 1'b1);
        check("mid_rel_no_resume", b4.tx_valid, 1'b0);
        exp_q = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        issue(8'h06, 16'h0001, 16'h0003, 8'h00);
        wait_accept();
        scramble_cmd();
        recv_frame(1'b0, "post_rst");

        // zero-gap instance: first byte the cycle after accept
        exp_q = '{8'h01, 8'h03, 8'h02, 8'hBE, 8'hEF};
        push_crc();
        @(negedge clk);
        b0.cmd_func = 8'h03; b0.cmd_reg = 16'h0000; b0.cmd_data = 16'hBEEF; b0.cmd_exc = 8'h00;
        b0.cmd_valid = 1'b1;
        cyc = 0;
        while (!b0.cmd_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("g0_ready", b0.cmd_ready, 1'b1);
        @(posedge clk); #1;
        b0.cmd_valid = 1'b0;
        @(negedge clk);
        check("g0_first_valid", b0.tx_valid, 1'b1);
        cyc = 0;
        while (!fd0 && cyc < 50) begin
            if (b0.tx_valid && b0.tx_ready) got0_q.push_back(b0.tx_byte);
            @(negedge clk);
            cyc++;
        end
        check("g0_done", fd0, 1'b1);
        check("g0_count", got0_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("g0_byte%0d", i), (i < got0_q.size()) ? got0_q[i] : 8'hxx, exp_q[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
